// File: rtl/modinv_keygen.sv
// Key generation for an RSA-style key pair: finds the smallest odd e >= e_init that is
// coprime to phi=(p-1)(q-1), and its inverse d, using iterative extended Euclid.
module modinv_keygen #(
  parameter int WIDTH     = 32,
  parameter int MAX_TRIES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic [2*WIDTH-1:0] e_init,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2*WIDTH-1:0] e,
  output logic [2*WIDTH-1:0] d
);
  localparam int W2 = 2*WIDTH;
  localparam int CW = $clog2(W2) + 1;
  localparam int TW = $clog2(MAX_TRIES + 1) + 1;

  typedef enum logic [2:0] {IDLE, INIT, DIV, UPDATE, CHECK, NEXT_E, DONE, FAIL} state_t;
  state_t state, state_nxt;

  logic [W2-1:0]        phi, cand, a, b, quo, rem;
  logic signed [W2:0]   t, t_prev, t_adj;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tries, tries_inc;
  logic [WIDTH-1:0]     pm1, qm1;
  logic [W2-1:0]        phi_new, cand_odd, cand0;
  logic [W2:0]          rsh, rdiff;
  logic                 accept, ge;

  assign accept    = start && (state == IDLE || state == DONE || state == FAIL);
  assign pm1       = p - WIDTH'(1);
  assign qm1       = q - WIDTH'(1);
  assign phi_new   = W2'(pm1) * W2'(qm1);
  assign cand_odd  = e_init | W2'(1);
  assign cand0     = (cand_odd < W2'(3)) ? W2'(3) : cand_odd;
  assign tries_inc = tries + TW'(1);
  assign t_adj     = t_prev + $signed({1'b0, phi});

  // Restoring divider step: shift the dividend MSB into the partial remainder.
  assign rsh   = {rem, quo[W2-1]};
  assign rdiff = rsh - {1'b0, b};
  assign ge    = (rsh >= {1'b0, b});

  assign busy  = !(state == IDLE || state == DONE || state == FAIL);
  assign done  = (state == DONE);
  assign error = (state == FAIL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (accept) state_nxt = INIT;
      INIT:   state_nxt = (cand >= phi) ? FAIL : DIV;
      DIV:    if (cnt == CW'(W2-1)) state_nxt = UPDATE;
      UPDATE: state_nxt = (rem != '0) ? DIV : CHECK;
      CHECK:  state_nxt = (a == W2'(1)) ? DONE : NEXT_E;
      NEXT_E: state_nxt = (tries_inc == TW'(MAX_TRIES)) ? FAIL : INIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0; d <= '0; tries <= '0; cnt <= '0;
      phi <= '0; cand <= '0; a <= '0; b <= '0; quo <= '0; rem <= '0;
      t <= '0; t_prev <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: if (accept) begin
          phi <= phi_new; cand <= cand0; tries <= '0;
          e <= '0; d <= '0;
        end
        INIT: begin
          a <= phi; b <= cand; t <= 1; t_prev <= '0;
          quo <= phi; rem <= '0; cnt <= '0;
        end
        DIV: begin
          quo <= {quo[W2-2:0], ge};
          rem <= ge ? rdiff[W2-1:0] : rsh[W2-1:0];
          cnt <= cnt + CW'(1);
        end
        UPDATE: begin
          a <= b; b <= rem;
          t_prev <= t;
          t <= t_prev - $signed({1'b0, quo}) * t;
          // the new dividend is the old divisor
          quo <= b; rem <= '0; cnt <= '0;
        end
        CHECK: if (a == W2'(1)) begin
          e <= cand;
          d <= (t_prev < 0) ? t_adj[W2-1:0] : t_prev[W2-1:0];
        end
        NEXT_E: begin
          tries <= tries_inc;
          cand  <= cand + W2'(2);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modinv_keygen.sv
// Scoreboard bench for modinv_keygen: expectations from spec constants and a brute-force model.
module tb_modinv_keygen;
  logic        clk = 0, reset = 1, start0 = 0, start1 = 0;
  logic [31:0] p = 0, q = 0;
  logic [63:0] e_init = 0;
  logic        busy0, done0, error0, busy1, done1, error1;
  logic [63:0] e0, d0, e1, d1;
  int checks = 0, failures = 0;

  typedef struct { logic [63:0] e; logic [63:0] d; logic err; } exp_t;
  exp_t sb[$];

  modinv_keygen dut (.clk(clk), .reset(reset), .start(start0), .p(p), .q(q), .e_init(e_init),
    .busy(busy0), .done(done0), .error(error0), .e(e0), .d(d0));
  modinv_keygen #(.WIDTH(32), .MAX_TRIES(1)) dut1 (.clk(clk), .reset(reset), .start(start1),
    .p(p), .q(q), .e_init(e_init), .busy(busy1), .done(done1), .error(error1), .e(e1), .d(d1));

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask

  function automatic longint gcd(input longint x, input longint y);
    longint r;
    while (y != 0) begin r = x % y; x = y; y = r; end
    return x;
  endfunction

  // Independent reference: gcd test per candidate, brute-force search for d.
  function automatic exp_t model(input longint pp, input longint qq, input longint ei, input int maxt);
    exp_t r; longint phi, cand; int tries;
    r.e = 0; r.d = 0; r.err = 1;
    phi = (pp - 1) * (qq - 1);
    cand = ei | 1; if (cand < 3) cand = 3;
    tries = 0;
    forever begin
      if (cand >= phi) return r;
      if (gcd(cand, phi) == 1) begin
        for (longint k = 0; k < phi; k++)
          if ((cand * k) % phi == 1) begin r.e = cand; r.d = k; r.err = 0; return r; end
        return r;
      end
      tries++;
      if (tries == maxt) return r;
      cand += 2;
    end
  endfunction

  function automatic exp_t mk(input longint ee, input longint dd, input bit err);
    exp_t r; r.e = ee; r.d = dd; r.err = err; return r;
  endfunction

  // Pulse start, wait for done/error, pop and compare. Optionally issue an ignored start mid-run.
  task automatic run(input string name, input bit inst, input longint pp, input longint qq,
                     input longint ei, input int exp_busy, input bit glitch);
    int cyc, busy_cyc; bit ok_mx; exp_t x;
    logic b_s, dn_s, er_s; logic [63:0] e_s, d_s;
    p = pp[31:0]; q = qq[31:0]; e_init = ei;
    if (inst) start1 = 1; else start0 = 1;
    tick();
    start0 = 0; start1 = 0;
    cyc = 0; busy_cyc = 0; ok_mx = 1;
    forever begin
      b_s = inst ? busy1 : busy0; dn_s = inst ? done1 : done0; er_s = inst ? error1 : error0;
      if ((32'(b_s) + 32'(dn_s) + 32'(er_s)) > 1) ok_mx = 0;
      if (dn_s || er_s || cyc > 20000) break;
      if (b_s) busy_cyc++;
      if (glitch && cyc == 5) begin p = 2; q = 3; e_init = 99; start0 = 1; start1 = 1; end
      else begin start0 = 0; start1 = 0; end
      tick(); cyc++;
    end
    start0 = 0; start1 = 0;
    x = sb.pop_front();
    e_s = inst ? e1 : e0; d_s = inst ? d1 : d0; er_s = inst ? error1 : error0; dn_s = inst ? done1 : done0;
    checks++; if (cyc > 20000) begin failures++; $display("FAIL %s timeout after %0d cycles", name, cyc); end
    checks++; if (er_s !== x.err) begin failures++; $display("FAIL %s error got %0b want %0b", name, er_s, x.err); end
    checks++; if (dn_s !== !x.err) begin failures++; $display("FAIL %s done got %0b want %0b", name, dn_s, !x.err); end
    checks++; if (e_s !== x.e) begin failures++; $display("FAIL %s e got %0d want %0d", name, e_s, x.e); end
    checks++; if (d_s !== x.d) begin failures++; $display("FAIL %s d got %0d want %0d", name, d_s, x.d); end
    checks++; if (!ok_mx) begin failures++; $display("FAIL %s busy/done/error overlap got 1 want 0", name); end
    if (exp_busy >= 0) begin
      checks++; if (busy_cyc !== exp_busy) begin failures++; $display("FAIL %s busy cycles got %0d want %0d", name, busy_cyc, exp_busy); end
    end
    // Outputs must stay held in DONE/FAIL.
    repeat (3) tick();
    e_s = inst ? e1 : e0; d_s = inst ? d1 : d0;
    checks++; if (e_s !== x.e || d_s !== x.d) begin failures++; $display("FAIL %s hold e/d got %0d/%0d want %0d/%0d", name, e_s, d_s, x.e, x.d); end
  endtask

  task automatic test_reset();
    reset = 1; start0 = 1; start1 = 1; p = 61; q = 53; e_init = 17;
    tick(); tick();
    start0 = 0; start1 = 0; reset = 0;
    checks++; if ({busy0, done0, error0} !== 3'b000) begin failures++; $display("FAIL reset flags got %b want 000", {busy0, done0, error0}); end
    checks++; if (e0 !== 64'd0 || d0 !== 64'd0) begin failures++; $display("FAIL reset e/d got %0d/%0d want 0/0", e0, d0); end
    tick();
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_prio busy got %b want 0", busy0); end
  endtask

  task automatic test_spec_vectors();
    sb.push_back(mk(7, 1783, 0));  run("rsa_e3", 0, 61, 53, 3, -1, 0);
    // 3120/17, 17/9, 9/8, 8/1: four Euclid steps of 65 cycles plus INIT and CHECK
    sb.push_back(mk(17, 2753, 0)); run("rsa_e17", 0, 61, 53, 17, 4*65 + 2, 0);
    sb.push_back(mk(3, 3, 0));     run("p3q5_e0", 0, 3, 5, 0, -1, 0);
    sb.push_back(mk(5, 5, 0));     run("p3q5_e4", 0, 3, 5, 4, -1, 0);
    sb.push_back(mk(0, 0, 1));     run("phi2_fail", 0, 2, 3, 3, -1, 0);
    sb.push_back(mk(0, 0, 1));     run("phi1_fail", 0, 2, 2, 0, -1, 0);
  endtask

  task automatic test_max_tries();
    sb.push_back(mk(0, 0, 1));     run("max_tries1", 1, 61, 53, 3, -1, 0);
    sb.push_back(mk(17, 2753, 0)); run("max_tries1_ok", 1, 61, 53, 17, -1, 0);
  endtask

  task automatic test_random();
    int primes[10] = '{5, 7, 11, 13, 17, 19, 23, 29, 31, 37};
    longint pp, qq, ei;
    for (int i = 0; i < 8; i++) begin
      pp = primes[$urandom_range(9)]; qq = primes[$urandom_range(9)]; ei = $urandom_range(40);
      sb.push_back(model(pp, qq, ei, 64));
      run("random", 0, pp, qq, ei, -1, 0);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back(mk(7, 1783, 0));
    p = 61; q = 53; e_init = 5; start0 = 1; tick(); start0 = 0;
    checks++; if ({busy0, done0} !== 2'b10) begin failures++; $display("FAIL b2b done_clear got %b want 10", {busy0, done0}); end
    while (!done0 && !error0) tick();
    checks++; if (e0 !== sb[0].e || d0 !== sb[0].d) begin failures++; $display("FAIL b2b e/d got %0d/%0d want %0d/%0d", e0, d0, sb[0].e, sb[0].d); end
    void'(sb.pop_front());
  endtask

  task automatic test_reset_mid_div();
    p = 61; q = 53; e_init = 17; start0 = 1; tick(); start0 = 0;
    repeat (10) tick();
    reset = 1; tick(); reset = 0;
    checks++; if ({busy0, done0, error0} !== 3'b000 || e0 !== 64'd0 || d0 !== 64'd0) begin
      failures++; $display("FAIL mid_div_reset got %b e=%0d d=%0d want 000 e=0 d=0", {busy0, done0, error0}, e0, d0); end
    sb.push_back(mk(17, 2753, 0)); run("after_reset_glitch", 0, 61, 53, 17, 4*65 + 2, 1);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_max_tries();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
